uart_rx_parity: RTL and testbench
=================================

UART_RX_PARITY -- requirements
Module: uart_rx_parity

Interface
REQ-001 Parameter DBIT, default 8, sets the number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, sets the stop-bit length in oversampling ticks (16 = 1 stop bit).
REQ-003 Parameter DVSR, default 163, sets the baud divisor; one tick every DVSR clocks gives 16x oversampling.
REQ-004 Parameter PARITY_ODD, default 0, selects parity: 0 = even, 1 = odd.
REQ-005 Parameter FIFO_W, default 2, sets the address width of the receive FIFO (4 entries).
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 Port rd_uart, input, 1 bit: pops the FIFO head.
REQ-010 Port clr_err, input, 1 bit: clears the sticky flags.
REQ-011 Port r_data, output, DBIT bits: data of the FIFO head.
REQ-012 Port error, output, 1 bit: parity-error flag of the FIFO head.
REQ-013 Port rx_empty, output, 1 bit: FIFO empty.
REQ-014 Port rx_full, output, 1 bit: FIFO full.
REQ-015 Port frame_err, output, 1 bit: sticky framing error.
REQ-016 Port overrun, output, 1 bit: sticky FIFO overrun.

Function
REQ-017 rx SHALL pass through a 2-FF synchronizer; both flops reset to 1.
REQ-018 The tick generator SHALL be a mod-DVSR counter that asserts tick for one clk when count equals DVSR-1, and SHALL free-run.
REQ-019 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP; it resets to IDLE.
REQ-020 IDLE: when synchronized rx is 0, go to START and clear the tick count s.
REQ-021 START: on the tick where s=7, if rx=0 go to DATA with s=0 and n=0; if rx=1 return to IDLE (glitch reject).
REQ-022 DATA: on the tick where s=15, shift rx into the MSB of the shift register (data is LSB-first) and set s=0; after the sample with n=DBIT-1, go to PARITY.
REQ-023 PARITY: on the tick where s=15, capture the parity bit p; perr = (XOR of data bits ^ p) != PARITY_ODD; then go to STOP.
REQ-024 STOP: on the tick where s=SB_TICK-1, sample rx and go to IDLE.
- If rx=0: set frame_err and discard the word.
- If rx=1: push {perr, data} to the FIFO.
REQ-025 The push SHALL take effect on the clk edge following the stop sample; rx_empty SHALL fall on that same edge.
REQ-026 FIFO behaviour:
- First-word-fall-through: r_data and error always show the head entry.
- rd_uart while empty is ignored.
REQ-027 Push while full without rd_uart: drop the word and set overrun. Push and rd_uart in the same cycle while full: both proceed, and the count is unchanged.
REQ-028 Pointers SHALL wrap modulo 2^FIFO_W. Full and empty SHALL be tracked by explicit registered flags.
REQ-029 clr_err SHALL clear frame_err and overrun on the next edge. A new set event in the same cycle SHALL take priority over clr_err.
REQ-030 While the FIFO is empty, r_data and error are don't-care, but SHALL be free of X after reset.

Reset
REQ-031 Asserting reset, including mid-frame, SHALL immediately do all of the following:
- FSM to IDLE.
- s, n, the shift register, the tick counter and both FIFO pointers to 0.
- rx_empty=1, rx_full=0, frame_err=0, overrun=0.
- r_data=0, error=0.
REQ-032 After reset deasserts, the first falling edge on rx SHALL be treated as a new start bit.

Structure
REQ-033 FSM state encoding and the default parameter constants SHALL live in the shared package uart_pkg.
REQ-034 The FIFO SHALL be a separate sub-module, rx_fifo, of width DBIT+1 and address width FIFO_W. The FSM and the tick generator stay in uart_rx_parity.

Verification
REQ-035 Bench parameters: DVSR=2. One bit time is therefore 32 clk.
REQ-036 Send 0xA5 with p=0 and stop=1 -> r_data=0xA5, error=0, rx_empty=0. Then pulse rd_uart -> rx_empty=1.
REQ-037 Send 0x01 with p=0 -> r_data=0x01, error=1, frame_err=0.
REQ-038 Send 0x3C with stop=0 -> frame_err=1, rx_empty stays 1. Then pulse clr_err -> frame_err=0.
REQ-039 Send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads -> rx_full=1 after 0x44, overrun=1 after 0x55. Four reads return 0x11 to 0x44, then rx_empty=1.
REQ-040 Drive rx low for 4 ticks, then high -> no push, FSM back in IDLE.
REQ-041 Assert reset in DATA after 3 bits -> all outputs at reset values. A following 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding and default parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int DEF_DBIT       = 8;
    localparam int DEF_SB_TICK    = 16;
    localparam int DEF_DVSR       = 163;
    localparam int DEF_PARITY_ODD = 0;
    localparam int DEF_FIFO_W     = 2;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through receive FIFO with registered full/empty flags.
module rx_fifo #(
    parameter int W  = 9,
    parameter int FW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full
);

    localparam int DEPTH = 2 ** FW;

    logic [W-1:0]  mem [DEPTH];
    logic [FW-1:0] w_ptr, r_ptr;
    logic          wr_en, rd_en;

    // A write while full only proceeds when a read frees a slot in the same cycle.
    assign wr_en  = wr & (~full | rd);
    assign rd_en  = rd & ~empty;
    assign r_data = mem[r_ptr];

    // Storage array, cleared on reset so the head is never X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[w_ptr] <= w_data;
        end
    end

    // Pointer and flag update; simultaneous read and write leave the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            case ({wr_en, rd_en})
                2'b01: begin
                    r_ptr <= r_ptr + FW'(1);
                    full  <= 1'b0;
                    empty <= (r_ptr + FW'(1)) == w_ptr;
                end
                2'b10: begin
                    w_ptr <= w_ptr + FW'(1);
                    empty <= 1'b0;
                    full  <= (w_ptr + FW'(1)) == r_ptr;
                end
                2'b11: begin
                    w_ptr <= w_ptr + FW'(1);
                    r_ptr <= r_ptr + FW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with parity check, 16x oversampling and a receive FIFO.
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int DBIT       = DEF_DBIT,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int DVSR       = DEF_DVSR,
    parameter int PARITY_ODD = DEF_PARITY_ODD,
    parameter int FIFO_W     = DEF_FIFO_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    input  logic            clr_err,
    output logic [DBIT-1:0] r_data,
    output logic            error,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    rx_state_t       state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            perr, perr_n;
    logic            rx_s1, rx_sync;
    logic [CW-1:0]   cnt;
    logic            tick;
    logic            push, frame_set, overrun_set;

    // Two-flop synchronizer for the asynchronous serial line, idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
        end
    end

    // Free-running mod-DVSR counter producing the 16x oversampling tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DVSR - 1));

    // Receiver FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
            perr  <= perr_n;
        end
    end

    // Next-state logic; push and frame_set are single-cycle strobes at the stop sample.
    always_comb begin
        state_n   = state;
        s_n       = s;
        n_n       = n;
        b_n       = b;
        perr_n    = perr;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s == SW'(7)) begin
                        if (!rx_sync) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == SW'(15)) begin
                        s_n = '0;
                        b_n = {rx_sync, b[DBIT-1:1]};
                        if (n == NW'(DBIT - 1)) begin
                            state_n = PARITY;
                        end else begin
                            n_n = n + NW'(1);
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s == SW'(15)) begin
                        perr_n  = ((^b) ^ rx_sync) != (PARITY_ODD != 0);
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        state_n = IDLE;
                        if (rx_sync) begin
                            push = 1'b1;
                        end else begin
                            frame_set = 1'b1;
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign overrun_set = push & rx_full & ~rd_uart;

    // Sticky error flags; a new set event wins over clr_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (overrun_set)  overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

    rx_fifo #(
        .W  (DBIT + 1),
        .FW (FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (push),
        .rd     (rd_uart),
        .w_data ({perr, b}),
        .r_data ({error, r_data}),
        .empty  (rx_empty),
        .full   (rx_full)
    );

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed self-checking bench for uart_rx_parity with DVSR=2 (32 clk per bit).
module tb_uart_rx_parity;
    import uart_pkg::*;

    localparam int BIT_CLK = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_uart;
    logic       clr_err;
    logic [7:0] r_data;
    logic       error;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    uart_rx_parity #(
        .DBIT       (8),
        .SB_TICK    (16),
        .DVSR       (2),
        .PARITY_ODD (0),
        .FIFO_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd_uart   (rd_uart),
        .clr_err   (clr_err),
        .r_data    (r_data),
        .error     (error),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(posedge clk);
    endtask

    // Full frame: start, 8 data bits LSB first, parity, stop (short low stop when stop_ok=0), idle gap.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_ok);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT_CLK);
        end
        rx = p;
        wait_clk(BIT_CLK);
        if (stop_ok) begin
            rx = 1'b1;
            wait_clk(BIT_CLK);
        end else begin
            rx = 1'b0;
            wait_clk(24);
            rx = 1'b1;
            wait_clk(8);
        end
        rx = 1'b1;
        wait_clk(2 * BIT_CLK);
        @(negedge clk);
    endtask

    task automatic pulse_rd();
        @(negedge clk) rd_uart = 1'b1;
        @(negedge clk) rd_uart = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_empty"},  32'(rx_empty),  32'd1);
        check({pfx, "_full"},   32'(rx_full),   32'd0);
        check({pfx, "_ferr"},   32'(frame_err), 32'd0);
        check({pfx, "_ovr"},    32'(overrun),   32'd0);
        check({pfx, "_rdata"},  32'(r_data),    32'd0);
        check({pfx, "_error"},  32'(error),     32'd0);
        check({pfx, "_state"},  32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        logic [7:0] exp_q [4];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset   = 1'b1;
        rx      = 1'b1;
        rd_uart = 1'b0;
        clr_err = 1'b0;
        wait_clk(4);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        wait_clk(4);
        @(negedge clk);

        // 0xA5 has four ones: even parity bit 0 is correct.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_data",  32'(r_data),   32'hA5);
        check("a5_error", 32'(error),    32'd0);
        check("a5_empty", 32'(rx_empty), 32'd0);
        pulse_rd();
        check("a5_pop_empty", 32'(rx_empty), 32'd1);

        // 0x01 has one one: parity bit 0 is wrong.
        send_frame(8'h01, 1'b0, 1'b1);
        check("01_data",  32'(r_data),    32'h01);
        check("01_error", 32'(error),     32'd1);
        check("01_ferr",  32'(frame_err), 32'd0);
        pulse_rd();

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        check("3c_ferr",  32'(frame_err), 32'd1);
        check("3c_empty", 32'(rx_empty),  32'd1);
        pulse_clr();
        check("3c_clr_ferr", 32'(frame_err), 32'd0);

        // Fill the FIFO and overflow it.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        check("fill3_full", 32'(rx_full), 32'd0);
        send_frame(8'h44, 1'b0, 1'b1);
        check("fill4_full", 32'(rx_full), 32'd1);
        check("fill4_ovr",  32'(overrun), 32'd0);
        send_frame(8'h55, 1'b0, 1'b1);
        check("fill5_ovr",  32'(overrun), 32'd1);
        check("fill5_full", 32'(rx_full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_data", i), 32'(r_data), 32'(exp_q[i]));
            check($sformatf("drain%0d_error", i), 32'(error), 32'd0);
            pulse_rd();
        end
        check("drain_empty", 32'(rx_empty), 32'd1);
        check("drain_full",  32'(rx_full),  32'd0);
        pulse_clr();
        check("clr_ovr", 32'(overrun), 32'd0);

        // Start-bit glitch of 4 ticks (8 clk).
        rx = 1'b0;
        wait_clk(8);
        rx = 1'b1;
        wait_clk(3 * BIT_CLK);
        @(negedge clk);
        check("glitch_empty", 32'(rx_empty),  32'd1);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_ferr",  32'(frame_err), 32'd0);

        // Leave a word and a frame error pending, then reset mid-frame after 3 data bits.
        send_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b0);
        check("pre_rst_empty", 32'(rx_empty),  32'd0);
        check("pre_rst_ferr",  32'(frame_err), 32'd1);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        rx = 1'b1; wait_clk(BIT_CLK);
        rx = 1'b0; wait_clk(BIT_CLK);
        rx = 1'b1; wait_clk(16);
        check("pre_rst_state", 32'(dut.state), 32'(DATA));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        rx = 1'b1;
        wait_clk(4);
        @(negedge clk);
        reset = 1'b0;
        wait_clk(2);
        @(negedge clk);
        check_reset_values("postrst");

        // 0x7E has six ones: even parity bit 0 is correct.
        send_frame(8'h7E, 1'b0, 1'b1);
        check("7e_data",  32'(r_data),    32'h7E);
        check("7e_error", 32'(error),     32'd0);
        check("7e_empty", 32'(rx_empty),  32'd0);
        check("7e_ferr",  32'(frame_err), 32'd0);
        pulse_rd();
        check("7e_pop_empty", 32'(rx_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
